// File: rtl/chip8_memory_if.sv
// CPU data port and ROM-loader stream port of the CHIP-8 main memory.
// The master side is the CPU/loader and the slave side is the memory.
interface chip8_memory_if;
    logic [11:0] mem_addr_in;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_data_out;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic [11:0] load_count;
    logic        load_error;
    logic        cpu_hold;

    modport master (
        output mem_addr_in, mem_read, mem_write, mem_wdata,
        output load_start, load_valid, load_data, load_last,
        input  mem_data_out, load_ready, load_count, load_error, cpu_hold
    );

    modport slave (
        input  mem_addr_in, mem_read, mem_write, mem_wdata,
        input  load_start, load_valid, load_data, load_last,
        output mem_data_out, load_ready, load_count, load_error, cpu_hold
    );
endinterface

// File: rtl/chip8_memory.sv
// 4 KiB CHIP-8 main memory: writes the font after reset, accepts program loads, and serves CPU reads/writes.
// Define CHIP8_MEM_READ_REG_EN to register mem_data_out (one cycle of read latency).
module chip8_memory #(
    parameter int          MEM_BYTES = 4096,
    parameter logic [11:0] FONT_BASE = 12'h050,
    parameter logic [11:0] PROG_BASE = 12'h200
) (
    input logic           clk,
    input logic           reset,
    chip8_memory_if.slave bus
);
    typedef enum logic [1:0] {FONT, RUN, LOAD} state_t;

    localparam logic [0:79][7:0] FONT_ROM = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    logic [7:0]  mem [0:MEM_BYTES-1];
    state_t      state;
    logic [6:0]  font_idx;
    logic [11:0] load_ptr;
    logic        load_ready_q;
    logic [11:0] load_count_q;
    logic        load_error_q;
    logic        cpu_hold_q;
    logic        accept;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;

    assign accept         = (state == LOAD) && bus.load_valid && load_ready_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_count = load_count_q;
    assign bus.load_error = load_error_q;
    assign bus.cpu_hold   = cpu_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FONT;
            font_idx     <= 7'd0;
            load_ptr     <= PROG_BASE;
            load_ready_q <= 1'b0;
            load_count_q <= 12'd0;
            load_error_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            case (state)
                FONT: begin
                    font_idx <= font_idx + 7'd1;
                    if (font_idx == 7'd79) begin
                        state      <= RUN;
                        font_idx   <= 7'd0;
                        cpu_hold_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.load_start) begin
                        state        <= LOAD;
                        load_ptr     <= PROG_BASE;
                        load_count_q <= 12'd0;
                        load_error_q <= 1'b0;
                        load_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_count_q <= load_count_q + 12'd1;
                        // The top address ends the load without wrapping the pointer.
                        if (bus.load_last || load_ptr == 12'hFFF) begin
                            state        <= RUN;
                            load_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            if (!bus.load_last) begin
                                load_error_q <= 1'b1;
                            end
                        end else begin
                            load_ptr <= load_ptr + 12'd1;
                        end
                    end
                end
                default: begin
                    state <= FONT;
                end
            endcase
        end
    end

    // One write port shared by the font sequencer, the loader, and the CPU.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.mem_addr_in;
        wr_data = bus.mem_wdata;
        case (state)
            FONT: begin
                wr_en   = 1'b1;
                wr_addr = FONT_BASE + {5'd0, font_idx};
                wr_data = FONT_ROM[font_idx];
            end
            RUN: begin
                wr_en = bus.mem_write;
            end
            LOAD: begin
                wr_en   = accept;
                wr_addr = load_ptr;
                wr_data = bus.load_data;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef CHIP8_MEM_READ_REG_EN
    logic [7:0] rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= 8'h00;
        end else if (bus.mem_read) begin
            rd_q <= mem[bus.mem_addr_in];
        end
    end

    assign bus.mem_data_out = rd_q;
`else
    assign bus.mem_data_out = bus.mem_read ? mem[bus.mem_addr_in] : 8'h00;
`endif
endmodule

// File: tb/tb_chip8_memory.sv
// Self-checking bench for chip8_memory: a byte-array model of memory plus load/hold status,
// compared every cycle against the DUT and pinned by hand-computed reads.
module tb_chip8_memory;
    logic clk = 1'b0;
    logic reset = 1'b1;

    chip8_memory_if bus();

    chip8_memory dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] glyphs [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    logic [7:0] model_mem [4096];
    bit         known [4096];
    int         font_left = 80;
    bit         loading = 1'b0;
    int         m_count = 0;
    bit         m_err = 1'b0;
    logic [7:0] m_rd = 8'h00;
    bit         m_rd_known = 1'b1;
    int         m_addr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Model: the font takes 80 edges after reset, then each loaded byte goes to 0x200 + bytes so far.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            font_left  = 80;
            loading    = 1'b0;
            m_count    = 0;
            m_err      = 1'b0;
            m_rd       = 8'h00;
            m_rd_known = 1'b1;
        end else begin
            if (bus.mem_read) begin
                m_rd       = model_mem[bus.mem_addr_in];
                m_rd_known = known[bus.mem_addr_in];
            end
            if (font_left > 0) begin
                m_addr = 12'h050 + (80 - font_left);
                model_mem[m_addr] = glyphs[80 - font_left];
                known[m_addr] = 1'b1;
                font_left--;
            end else if (loading) begin
                if (bus.load_valid) begin
                    m_addr = 12'h200 + m_count;
                    model_mem[m_addr] = bus.load_data;
                    known[m_addr] = 1'b1;
                    m_count++;
                    if (bus.load_last || m_addr == 12'hFFF) begin
                        loading = 1'b0;
                        if (!bus.load_last) m_err = 1'b1;
                    end
                end
            end else begin
                if (bus.mem_write) begin
                    model_mem[bus.mem_addr_in] = bus.mem_wdata;
                    known[bus.mem_addr_in] = 1'b1;
                end
                if (bus.load_start) begin
                    loading = 1'b1;
                    m_count = 0;
                    m_err   = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        checkOutput("cpu_hold", bus.cpu_hold, (font_left > 0) || loading);
        checkOutput("load_ready", bus.load_ready, loading);
        checkOutput("load_count", bus.load_count, m_count);
        checkOutput("load_error", bus.load_error, m_err);
`ifdef CHIP8_MEM_READ_REG_EN
        if (m_rd_known) checkOutput("read_data", bus.mem_data_out, m_rd);
`else
        if (!bus.mem_read) checkOutput("read_idle", bus.mem_data_out, 8'h00);
        else if (known[bus.mem_addr_in]) checkOutput("read_data", bus.mem_data_out, model_mem[bus.mem_addr_in]);
`endif
    end

    task automatic applyStimulus(input logic [11:0] addr, input logic rd, input logic wr,
                                 input logic [7:0] wd, input logic start);
        @(negedge clk);
        bus.mem_addr_in = addr;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.mem_wdata   = wd;
        bus.load_start  = start;
    endtask

    task automatic readCheck(input string name, input logic [11:0] addr, input logic [7:0] expected);
        applyStimulus(addr, 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef CHIP8_MEM_READ_REG_EN
        @(posedge clk);
`endif
        #1;
        checkOutput(name, bus.mem_data_out, expected);
    endtask

    task automatic startLoad();
        applyStimulus(12'h000, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] data, input logic last);
        int tries;
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        tries = 0;
        while (!bus.load_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL handshake_timeout: got load_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clk);
    endtask

    task automatic stopStream();
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.mem_addr_in = 12'h000;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = 8'h00;
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = 8'h00;
        bus.load_last   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_hold", bus.cpu_hold, 1'b1);
        checkOutput("reset_count", bus.load_count, 12'd0);
        reset = 1'b0;

        // Font: hold stays up for 79 edges and drops on the 80th; a load_start meanwhile is ignored.
        bus.load_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load_start = 1'b0;
        repeat (78) @(posedge clk);
        #1 checkOutput("hold_edge79", bus.cpu_hold, 1'b1);
        @(posedge clk);
        #1 checkOutput("hold_edge80", bus.cpu_hold, 1'b0);
        checkOutput("font_no_load", bus.load_ready, 1'b0);
        readCheck("font_050", 12'h050, 8'hF0);
        readCheck("font_054", 12'h054, 8'hF0);
        readCheck("font_09F", 12'h09F, 8'h80);

        // CPU write with same-cycle read returns the old byte.
        applyStimulus(12'h300, 1'b0, 1'b1, 8'h33, 1'b0);
        applyStimulus(12'h300, 1'b1, 1'b1, 8'h5A, 1'b0);
`ifndef CHIP8_MEM_READ_REG_EN
        #1 checkOutput("rw_old", bus.mem_data_out, 8'h33);
`endif
        readCheck("rw_new", 12'h300, 8'h5A);

        // Program load 00 E0 12 00.
        startLoad();
        sendByte(8'h00, 1'b0);
        sendByte(8'hE0, 1'b0);
        sendByte(8'h12, 1'b0);
        sendByte(8'h00, 1'b1);
        #1;
        checkOutput("prog_count", bus.load_count, 12'd4);
        checkOutput("prog_hold", bus.cpu_hold, 1'b0);
        stopStream();
        readCheck("prog_200", 12'h200, 8'h00);
        readCheck("prog_201", 12'h201, 8'hE0);
        readCheck("prog_203", 12'h203, 8'h00);

        // Backpressure gap plus a CPU write that must be dropped during LOAD.
        startLoad();
        applyStimulus(12'h300, 1'b0, 1'b1, 8'hC3, 1'b0);
        applyStimulus(12'h300, 1'b0, 1'b0, 8'h00, 1'b0);
        sendByte(8'hAA, 1'b0);
        stopStream();
        sendByte(8'hBB, 1'b1);
        stopStream();
        #1 checkOutput("bp_count", bus.load_count, 12'd2);
        readCheck("bp_200", 12'h200, 8'hAA);
        readCheck("bp_201", 12'h201, 8'hBB);
        readCheck("drop_300", 12'h300, 8'h5A);

        // Overflow: 3584 bytes fill 0x200..0xFFF, the 3585th is refused.
        startLoad();
        for (int k = 1; k <= 3584; k++) begin
            sendByte(8'(k ^ (k >> 8)), 1'b0);
        end
        @(negedge clk);
        bus.load_data = 8'h77;
        repeat (3) @(negedge clk);
        checkOutput("ovf_ready", bus.load_ready, 1'b0);
        checkOutput("ovf_error", bus.load_error, 1'b1);
        checkOutput("ovf_hold", bus.cpu_hold, 1'b0);
        checkOutput("ovf_count", bus.load_count, 12'hE00);
        stopStream();
        readCheck("ovf_FFF", 12'hFFF, 8'h0E);
        readCheck("ovf_200", 12'h200, 8'h01);

        // Reset in the middle of a load.
        startLoad();
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        stopStream();
        reset = 1'b1;
        #1;
        checkOutput("rst_hold", bus.cpu_hold, 1'b1);
        checkOutput("rst_count", bus.load_count, 12'd0);
        @(negedge clk);
        reset = 1'b0;
        readCheck("rst_200", 12'h200, 8'h11);
        repeat (82) @(posedge clk);
        #1 checkOutput("refont_hold", bus.cpu_hold, 1'b0);
        readCheck("refont_050", 12'h050, 8'hF0);

        applyStimulus(12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
